// File: rtl/dac_pulse_seq_if.sv
// Port bundle between the pulse sequencer and its control/DAC-side neighbours.
// The slave modport is the sequencer's view; the master modport drives it.
interface dac_pulse_seq_if #(
  parameter int LEN_W = 24
);
  logic                    dac_ready;
  logic                    sysref_i;
  logic                    trig;
  logic                    align_sysref;
  logic signed [15:0]      cfg_amp_i;
  logic signed [15:0]      cfg_amp_q;
  logic        [15:0]      cfg_step;
  logic        [LEN_W-1:0] cfg_hold_len;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic signed [15:0]      da_i0, da_i1, da_i2, da_i3;
  logic signed [15:0]      da_q0, da_q1, da_q2, da_q3;

  modport slave (
    input  dac_ready, sysref_i, trig, align_sysref,
    input  cfg_amp_i, cfg_amp_q, cfg_step, cfg_hold_len,
    output busy, done, err,
    output da_i0, da_i1, da_i2, da_i3,
    output da_q0, da_q1, da_q2, da_q3
  );

  modport master (
    output dac_ready, sysref_i, trig, align_sysref,
    output cfg_amp_i, cfg_amp_q, cfg_step, cfg_hold_len,
    input  busy, done, err,
    input  da_i0, da_i1, da_i2, da_i3,
    input  da_q0, da_q1, da_q2, da_q3
  );
endinterface

// File: rtl/dac_pulse_seq.sv
// Shaped I/Q pulse sequencer for the DAC0 lanes: linear ramp up, hold, ramp down,
// four samples per clock, optionally aligned to a SYSREF rising edge.
//
// state     | meaning
// IDLE      | no pulse, envelope 0, waiting for trig
// ARM       | pulse accepted, waiting for SYSREF rising edge
// RAMP_UP   | envelope rising by step per sample, clipped at full scale
// HOLD      | envelope at full scale for hold_len cycles
// RAMP_DOWN | envelope falling by step per sample, clipped at 0
module dac_pulse_seq #(
  parameter int LEN_W = 24
) (
  input logic            clk_user_bufg,
  input logic            rst_glb,
  dac_pulse_seq_if.slave bus
);
  localparam logic [16:0] ENV_FULL = 17'd32768;
  localparam logic [19:0] FULL20   = 20'd32768;

  typedef enum logic [2:0] {IDLE, ARM, RAMP_UP, HOLD, RAMP_DOWN} state_t;

  state_t             state, state_nxt;
  logic [18:0]        b, b_nxt;
  logic [LEN_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic signed [15:0] amp_i, amp_q;
  logic [15:0]        step;
  logic [LEN_W-1:0]   hold_len;
  logic               sysref_q, sref_edge;
  logic               accept, done_c, err_c;
  logic [19:0]        step_x [4];
  logic [19:0]        up_sum [4];
  logic signed [20:0] dn_diff [4];
  logic [16:0]        env [4];
  logic signed [33:0] prod_i [4];
  logic signed [33:0] prod_q [4];
  logic signed [15:0] da_i [4];
  logic signed [15:0] da_q [4];
  logic               act1, act2, done_q1, done_r, err_r;

  assign sref_edge = bus.sysref_i & ~sysref_q;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      step_x[j]  = 20'(step) * 20'(j + 1);
      up_sum[j]  = 20'(b) + step_x[j];
      dn_diff[j] = $signed({2'b00, b}) - $signed({1'b0, step_x[j]});
    end
  end

  always_comb begin
    state_nxt    = state;
    b_nxt        = b;
    hold_cnt_nxt = hold_cnt;
    accept       = 1'b0;
    done_c       = 1'b0;
    err_c        = 1'b0;
    for (int j = 0; j < 4; j++) env[j] = '0;

    if (state != IDLE && bus.trig) err_c = 1'b1;

    // Losing the link kills the pulse outright; envelope is zeroed this cycle too.
    if (state != IDLE && !bus.dac_ready) begin
      err_c        = 1'b1;
      state_nxt    = IDLE;
      b_nxt        = '0;
      hold_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.trig) begin
            if (bus.dac_ready) begin
              accept       = 1'b1;
              b_nxt        = '0;
              hold_cnt_nxt = bus.cfg_hold_len;
              if (bus.align_sysref)     state_nxt = ARM;
              else if (bus.cfg_step == 16'd0) state_nxt = HOLD;
              else                      state_nxt = RAMP_UP;
            end else begin
              err_c = 1'b1;
            end
          end
        end
        ARM: begin
          if (sref_edge) begin
            hold_cnt_nxt = hold_len;
            state_nxt    = (step == 16'd0) ? HOLD : RAMP_UP;
          end
        end
        RAMP_UP: begin
          for (int j = 0; j < 4; j++)
            env[j] = (up_sum[j] >= FULL20) ? ENV_FULL : up_sum[j][16:0];
          if (up_sum[3] >= FULL20) begin
            b_nxt        = 19'(ENV_FULL);
            hold_cnt_nxt = hold_len;
            state_nxt    = (hold_len == '0) ? RAMP_DOWN : HOLD;
          end else begin
            b_nxt = up_sum[3][18:0];
          end
        end
        HOLD: begin
          // A zero count here only happens for step=0/hold=0: emit nothing, finish.
          for (int j = 0; j < 4; j++)
            env[j] = (hold_cnt == '0) ? 17'd0 : ENV_FULL;
          if (hold_cnt <= LEN_W'(1)) begin
            hold_cnt_nxt = '0;
            b_nxt        = 19'(ENV_FULL);
            if (step == 16'd0) begin
              state_nxt = IDLE;
              done_c    = 1'b1;
            end else begin
              state_nxt = RAMP_DOWN;
            end
          end else begin
            hold_cnt_nxt = hold_cnt - LEN_W'(1);
          end
        end
        RAMP_DOWN: begin
          for (int j = 0; j < 4; j++)
            env[j] = (dn_diff[j] <= 21'sd0) ? 17'd0 : dn_diff[j][16:0];
          if (dn_diff[3] <= 21'sd0) begin
            b_nxt     = '0;
            state_nxt = IDLE;
            done_c    = 1'b1;
          end else begin
            b_nxt = dn_diff[3][18:0];
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_user_bufg) begin
    if (rst_glb) begin
      state    <= IDLE;
      b        <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      b        <= b_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Envelope -> product register -> output register: two cycles of latency.
  always_ff @(posedge clk_user_bufg) begin
    if (rst_glb) begin
      amp_i    <= '0;
      amp_q    <= '0;
      step     <= '0;
      hold_len <= '0;
      sysref_q <= 1'b0;
      act1     <= 1'b0;
      act2     <= 1'b0;
      done_q1  <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      for (int j = 0; j < 4; j++) begin
        prod_i[j] <= '0;
        prod_q[j] <= '0;
        da_i[j]   <= '0;
        da_q[j]   <= '0;
      end
    end else begin
      if (accept) begin
        amp_i    <= bus.cfg_amp_i;
        amp_q    <= bus.cfg_amp_q;
        step     <= bus.cfg_step;
        hold_len <= bus.cfg_hold_len;
      end
      sysref_q <= bus.sysref_i;
      act1     <= (state != IDLE);
      act2     <= act1;
      done_q1  <= done_c;
      done_r   <= done_q1;
      err_r    <= err_c;
      for (int j = 0; j < 4; j++) begin
        prod_i[j] <= 34'(amp_i) * 34'($signed({1'b0, env[j]}));
        prod_q[j] <= 34'(amp_q) * 34'($signed({1'b0, env[j]}));
        da_i[j]   <= 16'(prod_i[j] >>> 15);
        da_q[j]   <= 16'(prod_q[j] >>> 15);
      end
    end
  end

  assign bus.busy  = (state != IDLE) | act1 | act2;
  assign bus.done  = done_r;
  assign bus.err   = err_r;
  assign bus.da_i0 = da_i[0];
  assign bus.da_i1 = da_i[1];
  assign bus.da_i2 = da_i[2];
  assign bus.da_i3 = da_i[3];
  assign bus.da_q0 = da_q[0];
  assign bus.da_q1 = da_q[1];
  assign bus.da_q2 = da_q[2];
  assign bus.da_q3 = da_q[3];
endmodule

// File: tb/tb_dac_pulse_seq.sv
// Scoreboard bench for dac_pulse_seq: stimulus pushes the expected per-busy-cycle
// sample stream and error-pulse cycles; a negedge monitor pops and compares.
module tb_dac_pulse_seq;
  localparam int LEN_W = 24;

  typedef logic [3:0][16:0] env_t;
  typedef struct packed {
    logic [3:0][15:0] i;
    logic [3:0][15:0] q;
    logic             done;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  rec_t exp_q[$];
  int   err_q[$];
  rec_t mon_a, mon_e;
  int   mon_c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_pulse_seq_if #(.LEN_W(LEN_W)) bus();

  dac_pulse_seq #(.LEN_W(LEN_W)) dut (
    .clk_user_bufg(clk),
    .rst_glb(rst),
    .bus(bus.slave)
  );

  function automatic logic [15:0] smp(int amp, int e);
    longint p;
    p = longint'(amp) * longint'(e);
    return 16'(p >>> 15);
  endfunction

  // Envelope sequence straight from the pulse-shape rules, then turned into samples.
  task automatic model_push(int amp_i, int amp_q, int step, int hold, int lead, int abort_k);
    env_t envs[$];
    env_t s;
    rec_t r;
    int   b, v;
    if (step > 0) begin
      b = 0;
      for (int n = 0; n < 100000; n++) begin
        for (int j = 0; j < 4; j++) begin
          v = b + (j + 1) * step;
          s[j] = 17'((v > 32768) ? 32768 : v);
        end
        envs.push_back(s);
        if (s[3] == 17'd32768) break;
        b = b + 4 * step;
      end
    end
    if (step == 0 && hold == 0) envs.push_back('0);
    else for (int n = 0; n < hold; n++) envs.push_back({4{17'd32768}});
    if (step > 0) begin
      b = 32768;
      for (int n = 0; n < 100000; n++) begin
        for (int j = 0; j < 4; j++) begin
          v = b - (j + 1) * step;
          s[j] = 17'((v < 0) ? 0 : v);
        end
        envs.push_back(s);
        if (s[3] == 17'd0) break;
        b = b - 4 * step;
      end
    end
    if (abort_k >= 0) begin
      while (envs.size() > abort_k) void'(envs.pop_back());
      envs.push_back('0);
    end
    for (int n = 0; n < lead; n++) exp_q.push_back('0);
    foreach (envs[k]) begin
      for (int j = 0; j < 4; j++) begin
        r.i[j] = smp(amp_i, int'(envs[k][j]));
        r.q[j] = smp(amp_q, int'(envs[k][j]));
      end
      r.done = (abort_k < 0) && (k == envs.size() - 1);
      exp_q.push_back(r);
    end
  endtask

  task automatic run_pulse(int amp_i, int amp_q, int step, int hold, bit align, int sref_dly,
                           int abort_k, int xtrig_k, int rst_k, bit reject);
    int t0;
    int n;
    bit fin;
    @(posedge clk); #1;
    bus.cfg_amp_i    = 16'(amp_i);
    bus.cfg_amp_q    = 16'(amp_q);
    bus.cfg_step     = 16'(step);
    bus.cfg_hold_len = LEN_W'(hold);
    bus.align_sysref = align;
    bus.trig         = 1'b1;
    if (reject) bus.dac_ready = 1'b0;
    t0 = cyc;
    if (reject) err_q.push_back(t0 + 1);
    else model_push(amp_i, amp_q, step, hold, align ? 2 + sref_dly : 2, abort_k);
    if (xtrig_k >= 0) err_q.push_back(t0 + 2 + xtrig_k);
    if (abort_k >= 0) err_q.push_back(t0 + 2 + abort_k);
    n = 0;
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      n++;
      bus.trig = (xtrig_k >= 0 && cyc == t0 + 1 + xtrig_k);
      if (align && cyc == t0 + sref_dly) bus.sysref_i = 1'b1;
      else if (cyc == t0 + sref_dly + 2) bus.sysref_i = 1'b0;
      if (abort_k >= 0 && cyc == t0 + 1 + abort_k) bus.dac_ready = 1'b0;
      if (rst_k >= 0 && cyc == t0 + 1 + rst_k) rst = 1'b1;
      else if (rst_k >= 0 && cyc == t0 + 2 + rst_k) begin
        rst = 1'b0;
        exp_q.delete();
      end
      if (cyc > t0 + 3 && !bus.busy) fin = 1'b1;
      else if (n >= 400) begin
        total++;
        bad++;
        $display("FAIL pulse_timeout cyc=%0d busy still %0b, want 0", cyc, bus.busy);
        fin = 1'b1;
      end
    end
    bus.trig      = 1'b0;
    bus.sysref_i  = 1'b0;
    bus.dac_ready = 1'b1;
    rst           = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_a.i    = {bus.da_i3, bus.da_i2, bus.da_i1, bus.da_i0};
      mon_a.q    = {bus.da_q3, bus.da_q2, bus.da_q1, bus.da_q0};
      mon_a.done = bus.done;
      total++;
      if (bus.busy) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow cyc=%0d got busy with %h, want idle", cyc, mon_a);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_a !== mon_e) begin
            bad++;
            $display("FAIL samples cyc=%0d got=%h want=%h", cyc, mon_a, mon_e);
          end
        end
      end else if (mon_a !== '0) begin
        bad++;
        $display("FAIL idle_out cyc=%0d got=%h want=0", cyc, mon_a);
      end
      if (bus.err) begin
        total++;
        if (err_q.size() == 0) begin
          bad++;
          $display("FAIL err_unexpected cyc=%0d got err=1 want 0", cyc);
        end else begin
          mon_c = err_q.pop_front();
          if (mon_c != cyc) begin
            bad++;
            $display("FAIL err_cycle got cyc=%0d want cyc=%0d", cyc, mon_c);
          end
        end
      end
    end
  end

  initial begin
    int ai, aq, st, hl, r;
    bit al;
    rst              = 1'b1;
    bus.dac_ready    = 1'b1;
    bus.sysref_i     = 1'b0;
    bus.trig         = 1'b0;
    bus.align_sysref = 1'b0;
    bus.cfg_amp_i    = '0;
    bus.cfg_amp_q    = '0;
    bus.cfg_step     = '0;
    bus.cfg_hold_len = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_pulse(16384, -8192, 4096, 3, 0, 0, -1, -1, -1, 0);
    run_pulse(16384, -8192, 4096, 3, 1, 10, -1, -1, -1, 0);
    run_pulse(16384, -8192, 4096, 3, 0, 0, -1, -1, -1, 1);
    run_pulse(16384, -8192, 4096, 3, 0, 0, -1, 3, -1, 0);
    run_pulse(16384, -8192, 4096, 3, 0, 0, 3, -1, -1, 0);
    run_pulse(-12345, 23456, 3000, 1, 0, 0, -1, -1, -1, 0);
    run_pulse(16384, -8192, 0, 2, 0, 0, -1, -1, -1, 0);
    run_pulse(16384, -8192, 0, 0, 0, 0, -1, -1, -1, 0);
    run_pulse(16384, -8192, 32768, 2, 0, 0, -1, -1, -1, 0);
    run_pulse(16384, -8192, 256, 3, 0, 0, -1, -1, 5, 0);
    run_pulse(16384, -8192, 4096, 3, 0, 0, -1, -1, -1, 0);

    for (int k = 0; k < 12; k++) begin
      ai = int'($urandom_range(0, 65535)) - 32768;
      aq = int'($urandom_range(0, 65535)) - 32768;
      r  = int'($urandom_range(0, 9));
      st = (r == 0) ? 0 : (r == 1) ? 65535 : int'($urandom_range(1500, 33000));
      hl = int'($urandom_range(0, 5));
      al = 1'($urandom_range(0, 1));
      run_pulse(ai, aq, st, hl, al, int'($urandom_range(1, 8)), -1, -1, -1, 0);
    end

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got %0d records, want 0", exp_q.size());
    end
    total++;
    if (err_q.size() != 0) begin
      bad++;
      $display("FAIL err_missing got %0d pending, want 0", err_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dac_pulse_seq.md
# dac_pulse_seq

Pulse sequencer that feeds the AD9172 DAC interface's DAC0 parallel sample inputs with amplitude-shaped microwave interrogation pulses. On a trigger it optionally waits for a SYSREF edge, then ramps an envelope up linearly, holds it, and ramps it down. Output is I/Q at 4 samples per `clk_user_bufg` cycle, driving `da0i_ch00..03` / `da0q_ch00..03`. It sits directly upstream of the DAC interface and uses that interface's `dac_ready` and `sysref_o` outputs as inputs.

## Interface
- `LEN_W`, 24: width of hold-length counter.

- `clk_user_bufg`  in  1  user/sample clock; single clock domain.
- `rst_glb`  in  1  synchronous, active-high reset.
- `dac_ready`  in  1  DAC link up; pulses are accepted and run only while high.
- `sysref_i`  in  1  SYSREF from DAC interface, already synchronous to `clk_user_bufg`.
- `trig`  in  1  start request, sampled every cycle.
- `align_sysref`  in  1  1: start on next SYSREF rising edge; 0: start immediately.
- `cfg_amp_i`, `cfg_amp_q`  in  16 each  signed carrier amplitude.
- `cfg_step`  in  16  unsigned envelope increment per sample (Q1.15); 0 = no ramp.
- `cfg_hold_len`  in  LEN_W  hold duration in cycles; 0 allowed.
- `busy`  out  1  pulse in progress or pipeline not drained.
- `done`  out  1  one-cycle pulse at normal pulse completion.
- `err`  out  1  one-cycle pulse on rejected trigger or abort.
- `da_i0..da_i3`, `da_q0..da_q3`  out  16 each  signed samples; index 0 is the earliest in time.

## Operation
- All outputs reset to 0. State resets to IDLE; the envelope base `b` (19-bit unsigned) resets to 0.
- States: IDLE, ARM, RAMP_UP, HOLD, RAMP_DOWN.
- **IDLE** (`trig`=1):
  - If `dac_ready`=1, latch all `cfg_*` and `align_sysref`. Go to ARM if `align_sysref`=1, else to RAMP_UP (or HOLD if `cfg_step`=0).
  - If `dac_ready`=0, pulse `err` and stay in IDLE.
- **ARM**: wait for a SYSREF rising edge, detected as `sysref_i`=1 with the registered previous value 0. Then go to RAMP_UP (or HOLD if step=0) on the next cycle.
- **Trigger while not IDLE**: ignored, and `err` pulses.
- **RAMP_UP**: per-sample envelope `e[j] = min(b + (j+1)*step, 32768)` for j=0..3. Then `b <= b + 4*step`.
  - Exit when `e[3]` = 32768 that cycle: to HOLD, or to RAMP_DOWN if `hold_len`=0.
- **HOLD**: `e[j]` = 32768. Counts `hold_len` cycles, then goes to RAMP_DOWN (or IDLE if step=0). Set `b` = 32768 on exit.
- **RAMP_DOWN**: `e[j] = max(b - (j+1)*step, 0)`, then `b <= b - 4*step`.
  - Exit to IDLE when `e[3]` = 0 that cycle. `done` is asserted.
- **step=0 and hold_len=0**: trigger accepted, no nonzero output, `done` still pulses.
- **IDLE/ARM**: `e[j]` = 0.
- **Sample arithmetic**: `da_i[j] = (amp_i * e[j]) >>> 15`, 16x17-bit signed product, arithmetic shift (floor). Same for Q. The result always fits 16 bits; no saturation is needed.
- **Abort**: `dac_ready` falling in ARM/RAMP_UP/HOLD/RAMP_DOWN forces IDLE next cycle, envelope 0 and `b` 0. `err` pulses and `done` does not.
- **`rst_glb` mid-pulse**: immediate return to reset values; no `done`, no `err`.

## Timing
- Envelope register updates in the cycle the state is entered. A multiply register stage follows, then the output register. Outputs therefore reflect the envelope 2 cycles later.
- `trig` at cycle T, align=0: first nonzero samples at T+3.
- `trig` at cycle T, align=1, edge seen at cycle S: first nonzero samples at S+3.
- `busy` rises at T+1 and falls the cycle after the final zero samples are output.
- `done` coincides with the output of the last RAMP_DOWN sample set.
- `err` is registered: asserted 1 cycle after the causing event.
- Throughput: one 4-sample set per cycle, no stalls.

## Test plan
- **Basic pulse**: amp_i=16384, amp_q=-8192, step=4096, hold=3, align=0, trig at T.
  - From T+3: I=2048,4096,6144,8192; then 10240,12288,14336,16384.
  - Then 3 cycles of 16384 (Q -8192).
  - Then 14336,12288,10240,8192; then 6144,4096,2048,0, with `done` on that cycle.
  - Q throughout = −I/2.
- **SYSREF alignment**: align=1, trig at T, `sysref_i` rises at T+10 → no output before T+13; first samples at T+13 match the basic pulse.
- **Rejected and ignored triggers**:
  - `dac_ready`=0 with trig → `err` at T+1, outputs stay 0, `busy` stays 0.
  - Second trig during HOLD → `err` pulses; waveform unchanged.
- **Abort**: drop `dac_ready` mid-HOLD → outputs 0 within 3 cycles, `err` pulses once, no `done`, `busy` falls; the next trig runs normally.
- **Corner configs**:
  - step=0, hold=2 → 2 cycles at full amplitude, then `done`.
  - step=0, hold=0 → `done` only, with no nonzero output.
  - step=32768 → 1-cycle ramps with samples 16384 on every lane for amp_i=16384.
- **Reset**: assert `rst_glb` during RAMP_UP → all outputs 0 next cycle, state IDLE, no `done` or `err`.
